// File: rtl/cam_stream_gen.sv
// Replays a stored 3-bit-per-pixel frame as an OV-style camera stream (pclk, vsync, href, d).
// Frame RAM reads are issued one sysclk ahead of each active pixel boundary.
module cam_stream_gen #(
  parameter int H_ACTIVE = 256,
  parameter int H_BLANK  = 64,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 17,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 10
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] rdaddr,
  output logic        rden,
  input  logic [2:0]  q,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [2:0]  d,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int V_MAX01 = (V_SYNC > V_BP) ? V_SYNC : V_BP;
  localparam int V_MAX23 = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int V_MAX   = (V_MAX01 > V_MAX23) ? V_MAX01 : V_MAX23;
  localparam int VW      = $clog2(V_MAX + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t          state, nxt_state;
  logic [HW-1:0]   hcnt, nxt_hcnt;
  logic [VW-1:0]   vcnt, nxt_vcnt;
  logic [VW-1:0]   v_last;
  logic            phase;
  logic [15:0]     addr;
  logic            nxt_href;
  logic            nxt_vsync;
  logic            frame_end;
  logic            enter_vsync;

  assign pclk = phase;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else if (phase) begin
      state <= nxt_state;
      hcnt  <= nxt_hcnt;
      vcnt  <= nxt_vcnt;
    end
  end

  // Next-pixel view: evaluated on both phases so the read for the upcoming
  // pixel can be issued half a pixel before the boundary that commits it.
  always_comb begin
    nxt_state = state;
    nxt_hcnt  = hcnt;
    nxt_vcnt  = vcnt;
    frame_end = 1'b0;
    case (state)
      S_VSYNC:  v_last = VW'(V_SYNC - 1);
      S_VBACK:  v_last = VW'(V_BP - 1);
      S_ACTIVE: v_last = VW'(V_ACTIVE - 1);
      S_VFRONT: v_last = VW'(V_FP - 1);
      default:  v_last = '0;
    endcase
    if (state == S_IDLE) begin
      if (en) begin
        nxt_state = S_VSYNC;
        nxt_hcnt  = '0;
        nxt_vcnt  = '0;
      end
    end else if (hcnt == H_LAST) begin
      nxt_hcnt = '0;
      if (vcnt == v_last) begin
        nxt_vcnt = '0;
        case (state)
          S_VSYNC:  nxt_state = S_VBACK;
          S_VBACK:  nxt_state = S_ACTIVE;
          S_ACTIVE: nxt_state = S_VFRONT;
          S_VFRONT: begin
            frame_end = 1'b1;
            nxt_state = en ? S_VSYNC : S_IDLE;
          end
          default:  nxt_state = S_IDLE;
        endcase
      end else begin
        nxt_vcnt = vcnt + 1'b1;
      end
    end else begin
      nxt_hcnt = hcnt + 1'b1;
    end
    nxt_vsync   = (nxt_state == S_VSYNC);
    nxt_href    = (nxt_state == S_ACTIVE) && (nxt_hcnt < H_ACT);
    enter_vsync = (nxt_state == S_VSYNC) && (state != S_VSYNC);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      phase      <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= '0;
      rden       <= 1'b0;
      rdaddr     <= '0;
      addr       <= '0;
      frame_done <= 1'b0;
    end else begin
      phase      <= ~phase;
      frame_done <= 1'b0;
      if (phase) begin
        vsync      <= nxt_vsync;
        href       <= nxt_href;
        d          <= nxt_href ? q : '0;
        frame_done <= frame_end;
        rden       <= 1'b0;
        if (enter_vsync) addr <= '0;
      end else begin
        rden <= nxt_href;
        if (nxt_href) begin
          rdaddr <= addr;
          addr   <= addr + 16'd1;
        end
      end
    end
  end

endmodule
